// File: rtl/usb_pkg.sv
// usb_pkg: shared USB control-endpoint state encodings and PID constants
package usb_pkg;
  typedef enum logic [1:0] {FILL, READY, XMIT, STALLED} in_state_t;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam int B_MAX_PACKET_SIZE0 = 32;
endpackage

// File: rtl/usb_pkt_ram.sv
// usb_pkt_ram: single-packet payload store, one write port, async read port
module usb_pkt_ram #(
  parameter int DEPTH = 32,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/usb_ctrl_in_pkt_buf.sv
// usb_ctrl_in_pkt_buf: control-endpoint IN packet buffer with DATA0/1 toggle,
// lost-ACK retransmit and stall handling
module usb_ctrl_in_pkt_buf
  import usb_pkg::*;
#(
  parameter int MAX_PKT_SIZE = B_MAX_PACKET_SIZE0,
  parameter int PTR_W = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_ep_req,
  output logic       in_ep_grant,
  output logic       in_ep_data_free,
  input  logic       in_ep_data_put,
  input  logic [7:0] in_ep_data,
  input  logic       in_ep_data_done,
  input  logic       in_ep_stall,
  output logic       in_ep_acked,
  input  logic       setup_token,
  input  logic       in_token,
  output logic       tx_pkt_ready,
  output logic       tx_stall,
  output logic       tx_data_toggle,
  output logic       tx_data_avail,
  input  logic       tx_data_get,
  output logic [7:0] tx_data,
  input  logic       tx_acked
);
  localparam int AW = $clog2(MAX_PKT_SIZE);
  localparam logic [PTR_W-1:0] MAX_CNT = PTR_W'(MAX_PKT_SIZE);
  in_state_t state, state_n;
  logic [PTR_W-1:0] wr_cnt, wr_n, rd_ptr, rd_n;
  logic toggle, tog_n, acked_n, wr_en;
  logic [7:0] rdata;
  assign in_ep_grant = in_ep_req && state == FILL;
  assign in_ep_data_free = state == FILL && wr_cnt < MAX_CNT;
  assign tx_pkt_ready = state == READY || state == XMIT;
  assign tx_stall = state == STALLED;
  assign tx_data_toggle = toggle;
  assign tx_data_avail = state == XMIT && rd_ptr < wr_cnt;
  assign tx_data = state == XMIT ? rdata : 8'h00;
  // setup and stall both flush the packet, so a coincident put must not land
  assign wr_en = in_ep_data_put && in_ep_data_free && !setup_token && !in_ep_stall;
  usb_pkt_ram #(.DEPTH(MAX_PKT_SIZE), .AW(AW)) u_ram (
    .clk(clk),
    .we(wr_en),
    .waddr(wr_cnt[AW-1:0]),
    .wdata(in_ep_data),
    .raddr(rd_ptr[AW-1:0]),
    .rdata(rdata)
  );
  always_comb begin
    state_n = state;
    wr_n = wr_cnt;
    rd_n = rd_ptr;
    tog_n = toggle;
    acked_n = 1'b0;
    if (setup_token) begin
      state_n = FILL;
      wr_n = '0;
      rd_n = '0;
      tog_n = 1'b1;
    end else if (in_ep_stall) begin
      state_n = STALLED;
      wr_n = '0;
      rd_n = '0;
    end else begin
      case (state)
        FILL: begin
          wr_n = wr_en ? wr_cnt + 1'b1 : wr_cnt;
          state_n = (in_ep_data_done || (wr_en && wr_cnt == MAX_CNT - 1'b1)) ? READY : FILL;
        end
        READY: begin
          rd_n = in_token ? '0 : rd_ptr;
          state_n = in_token ? XMIT : READY;
        end
        XMIT: begin
          if (tx_acked) begin
            tog_n = ~toggle;
            wr_n = '0;
            rd_n = '0;
            acked_n = 1'b1;
            state_n = FILL;
          end else if (in_token) rd_n = '0;
          else if (tx_data_get && tx_data_avail) rd_n = rd_ptr + 1'b1;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FILL;
      wr_cnt <= '0;
      rd_ptr <= '0;
      toggle <= 1'b0;
      in_ep_acked <= 1'b0;
    end else begin
      state <= state_n;
      wr_cnt <= wr_n;
      rd_ptr <= rd_n;
      toggle <= tog_n;
      in_ep_acked <= acked_n;
    end
  end
endmodule

// File: tb/tb_usb_ctrl_in_pkt_buf.sv
// tb_usb_ctrl_in_pkt_buf: directed self-checking bench for the control IN packet buffer
module tb_usb_ctrl_in_pkt_buf;
  logic clk = 1'b0, reset = 1'b0;
  logic in_ep_req = 1'b0, in_ep_data_put = 1'b0, in_ep_data_done = 1'b0, in_ep_stall = 1'b0;
  logic setup_token = 1'b0, in_token = 1'b0, tx_data_get = 1'b0, tx_acked = 1'b0;
  logic [7:0] in_ep_data = 8'h00;
  logic in_ep_grant, in_ep_data_free, in_ep_acked, tx_pkt_ready, tx_stall, tx_data_toggle, tx_data_avail;
  logic [7:0] tx_data;
  int vectors = 0, miscompares = 0;
  logic exp_tog = 1'b0;
  logic [7:0] pkt [64];

  usb_ctrl_in_pkt_buf dut (
    .clk(clk), .reset(reset), .in_ep_req(in_ep_req), .in_ep_grant(in_ep_grant),
    .in_ep_data_free(in_ep_data_free), .in_ep_data_put(in_ep_data_put), .in_ep_data(in_ep_data),
    .in_ep_data_done(in_ep_data_done), .in_ep_stall(in_ep_stall), .in_ep_acked(in_ep_acked),
    .setup_token(setup_token), .in_token(in_token), .tx_pkt_ready(tx_pkt_ready), .tx_stall(tx_stall),
    .tx_data_toggle(tx_data_toggle), .tx_data_avail(tx_data_avail), .tx_data_get(tx_data_get),
    .tx_data(tx_data), .tx_acked(tx_acked)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] d, input logic done);
    in_ep_data_put = 1'b1;
    in_ep_data = d;
    in_ep_data_done = done;
    step();
    in_ep_data_put = 1'b0;
    in_ep_data_done = 1'b0;
  endtask

  task automatic fill(input int n, input logic done_on_last);
    for (int i = 0; i < n; i++) put(pkt[i], done_on_last && i == n - 1);
  endtask

  task automatic token();
    in_token = 1'b1;
    step();
    in_token = 1'b0;
  endtask

  task automatic get();
    tx_data_get = 1'b1;
    step();
    tx_data_get = 1'b0;
  endtask

  task automatic ack();
    tx_acked = 1'b1;
    step();
    tx_acked = 1'b0;
  endtask

  task automatic read_pkt(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      vectors++;
      if ({tx_data_avail, tx_data} !== {1'b1, pkt[i]}) begin
        miscompares++;
        $display("FAIL %s byte %0d: got avail=%b data=%h, want avail=1 data=%h", name, i, tx_data_avail, tx_data, pkt[i]);
      end
      get();
    end
    vectors++;
    if (tx_data_avail !== 1'b0) begin
      miscompares++;
      $display("FAIL %s avail_after_last: got %b, want 0", name, tx_data_avail);
    end
  endtask

  task automatic check_ack(input string name);
    ack();
    exp_tog = ~exp_tog;
    vectors++;
    if ({in_ep_acked, tx_data_toggle, tx_pkt_ready, in_ep_data_free} !== {1'b1, exp_tog, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL %s ack: got acked/tog/ready/free=%b%b%b%b, want 1%b01", name, in_ep_acked, tx_data_toggle, tx_pkt_ready, in_ep_data_free, exp_tog);
    end
    step();
    vectors++;
    if (in_ep_acked !== 1'b0) begin
      miscompares++;
      $display("FAIL %s ack_pulse_width: got %b, want 0", name, in_ep_acked);
    end
  endtask

  task automatic test_reset();
    in_ep_req = 1'b1;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    vectors++;
    if ({in_ep_grant, in_ep_data_free, tx_pkt_ready, tx_stall, tx_data_toggle, tx_data_avail, in_ep_acked, tx_data}
        !== {7'b1100000, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b%b%b%b%b%b%b %h, want 1100000 00", in_ep_grant, in_ep_data_free,
               tx_pkt_ready, tx_stall, tx_data_toggle, tx_data_avail, in_ep_acked, tx_data);
    end
    ack();
    vectors++;
    if ({in_ep_acked, tx_data_toggle} !== 2'b00) begin
      miscompares++;
      $display("FAIL stray_ack: got acked=%b tog=%b, want 0 0", in_ep_acked, tx_data_toggle);
    end
  endtask

  task automatic test_short_pkt();
    for (int i = 0; i < 18; i++) pkt[i] = (i == 0) ? 8'h12 : 8'(i);
    fill(18, 1'b0);
    vectors++;
    if ({in_ep_data_free, tx_pkt_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL short_fill: got free=%b ready=%b, want 1 0", in_ep_data_free, tx_pkt_ready);
    end
    token();
    vectors++;
    if (tx_pkt_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL short_token_in_fill: got ready=%b, want 0", tx_pkt_ready);
    end
    in_ep_data_done = 1'b1;
    step();
    in_ep_data_done = 1'b0;
    vectors++;
    if ({tx_pkt_ready, in_ep_data_free, in_ep_grant} !== 3'b100) begin
      miscompares++;
      $display("FAIL short_done: got ready/free/grant=%b%b%b, want 100", tx_pkt_ready, in_ep_data_free, in_ep_grant);
    end
    token();
    read_pkt("short", 18);
    get();
    vectors++;
    if ({tx_data_avail, tx_pkt_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL short_extra_get: got avail=%b ready=%b, want 0 1", tx_data_avail, tx_pkt_ready);
    end
    check_ack("short");
  endtask

  task automatic test_full_pkt();
    setup_token = 1'b1;
    in_ep_data_put = 1'b1;
    in_ep_data = 8'h5A;
    step();
    setup_token = 1'b0;
    in_ep_data_put = 1'b0;
    exp_tog = 1'b1;
    vectors++;
    if ({tx_data_toggle, in_ep_data_free, tx_pkt_ready} !== 3'b110) begin
      miscompares++;
      $display("FAIL full_setup: got tog/free/ready=%b%b%b, want 110", tx_data_toggle, in_ep_data_free, tx_pkt_ready);
    end
    for (int i = 0; i < 32; i++) pkt[i] = 8'hA0 ^ 8'(i);
    fill(31, 1'b0);
    vectors++;
    if ({in_ep_data_free, tx_pkt_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL full_31: got free=%b ready=%b, want 1 0", in_ep_data_free, tx_pkt_ready);
    end
    put(pkt[31], 1'b0);
    vectors++;
    if ({in_ep_data_free, tx_pkt_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL full_32: got free=%b ready=%b, want 0 1", in_ep_data_free, tx_pkt_ready);
    end
    put(8'hFF, 1'b0);
    token();
    vectors++;
    if (tx_data_toggle !== 1'b1) begin
      miscompares++;
      $display("FAIL full_toggle: got %b, want 1", tx_data_toggle);
    end
    read_pkt("full", 32);
    check_ack("full");
  endtask

  task automatic test_zlp();
    in_ep_data_done = 1'b1;
    step();
    in_ep_data_done = 1'b0;
    token();
    vectors++;
    if ({tx_pkt_ready, tx_data_avail} !== 2'b10) begin
      miscompares++;
      $display("FAIL zlp: got ready=%b avail=%b, want 1 0", tx_pkt_ready, tx_data_avail);
    end
    check_ack("zlp");
  endtask

  task automatic test_lost_ack();
    for (int i = 0; i < 8; i++) pkt[i] = 8'h30 + 8'(i);
    fill(8, 1'b1);
    token();
    for (int i = 0; i < 5; i++) get();
    vectors++;
    if (tx_data !== pkt[5]) begin
      miscompares++;
      $display("FAIL lost_ack_mid: got %h, want %h", tx_data, pkt[5]);
    end
    token();
    vectors++;
    if ({tx_data_toggle, tx_data_avail, tx_data} !== {exp_tog, 1'b1, pkt[0]}) begin
      miscompares++;
      $display("FAIL lost_ack_retry: got tog=%b avail=%b data=%h, want %b 1 %h", tx_data_toggle, tx_data_avail, tx_data, exp_tog, pkt[0]);
    end
    read_pkt("lost_ack", 8);
    check_ack("lost_ack");
  endtask

  task automatic test_stall();
    for (int i = 0; i < 4; i++) pkt[i] = 8'hC0 + 8'(i);
    fill(4, 1'b0);
    in_ep_stall = 1'b1;
    step();
    in_ep_stall = 1'b0;
    vectors++;
    if ({tx_stall, in_ep_data_free, tx_pkt_ready, in_ep_grant} !== 4'b1000) begin
      miscompares++;
      $display("FAIL stall: got stall/free/ready/grant=%b%b%b%b, want 1000", tx_stall, in_ep_data_free, tx_pkt_ready, in_ep_grant);
    end
    token();
    put(8'h77, 1'b1);
    vectors++;
    if ({tx_stall, tx_pkt_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL stall_token: got stall=%b ready=%b, want 1 0", tx_stall, tx_pkt_ready);
    end
    setup_token = 1'b1;
    step();
    setup_token = 1'b0;
    exp_tog = 1'b1;
    vectors++;
    if ({tx_stall, in_ep_data_free, tx_data_toggle} !== 3'b011) begin
      miscompares++;
      $display("FAIL stall_setup: got stall/free/tog=%b%b%b, want 011", tx_stall, in_ep_data_free, tx_data_toggle);
    end
    in_ep_data_done = 1'b1;
    step();
    in_ep_data_done = 1'b0;
    token();
    vectors++;
    if ({tx_pkt_ready, tx_data_avail} !== 2'b10) begin
      miscompares++;
      $display("FAIL stall_flushed: got ready=%b avail=%b, want 1 0", tx_pkt_ready, tx_data_avail);
    end
    check_ack("stall");
  endtask

  task automatic test_reset_in_xmit();
    for (int i = 0; i < 6; i++) pkt[i] = 8'hE0 + 8'(i);
    fill(6, 1'b1);
    token();
    for (int i = 0; i < 3; i++) get();
    vectors++;
    if (tx_data !== pkt[3]) begin
      miscompares++;
      $display("FAIL xmit_pre_reset: got %h, want %h", tx_data, pkt[3]);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_tog = 1'b0;
    vectors++;
    if ({in_ep_data_free, tx_pkt_ready, tx_stall, tx_data_toggle, tx_data_avail, in_ep_acked, tx_data}
        !== {6'b100000, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_in_xmit: got %b%b%b%b%b%b %h, want 100000 00", in_ep_data_free, tx_pkt_ready,
               tx_stall, tx_data_toggle, tx_data_avail, in_ep_acked, tx_data);
    end
  endtask

  initial begin
    test_reset();
    test_short_pkt();
    test_full_pkt();
    test_zlp();
    test_lost_ack();
    test_stall();
    test_reset_in_xmit();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
